plru_set_ctrl: RTL
==================

Name: plru_set_ctrl

Overview:
Parametrised tree-PLRU replacement controller for a set-associative cache. It holds one (WAYS-1)-bit PLRU tree per set and accepts one request per cycle: touch (hit), victim (select and fill), or clear. Each request is handled as a 2-stage read-modify-write, with same-set bypass. It sits beside the tag array and supplies victim ways to the fill path.

Parameters:
WAYS, 8, associativity; power of 2, minimum 2
WAYS_REP, $clog2(WAYS), width of the way index
SETS, 64, number of sets; power of 2
SET_BITS, $clog2(SETS), width of the set index

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  request can be accepted; low during the init sweep
req_op  input  2  00 TOUCH, 01 VICTIM, 10 CLEAR, 11 reserved (treated as TOUCH)
req_set  input  SET_BITS  target set
req_way  input  WAYS_REP  way being touched (TOUCH only)
rsp_valid  output  1  one-cycle pulse per accepted request
rsp_way  output  WAYS_REP  VICTIM: chosen way; TOUCH: req_way; CLEAR: 0
init_done  output  1  high once the post-reset sweep has finished

Behaviour:
- Tree encoding: heap order. Node 0 is the root; node i has children 2i+1 and 2i+2. Leaf node (WAYS-1)+w is way w. Node bit 0 means the victim lies in the left subtree; 1 means the right subtree.
- Touch way w: every node on w's root-to-leaf path is set to point away from w. Nodes off the path keep their value.
- Victim: walk from the root following node bits. The resulting way is returned and also touched (fill implies use).
- CLEAR: writes all-zero bits to the set, so its next victim is way 0.
- Reset (asynchronous, rst_n low): rsp_valid=0, rsp_way=0, init_done=0, req_ready=0, pipeline valid bits=0, init counter=0. Array contents are not reset directly.
- State machine INIT: entered on reset. Writes zero to set[cnt] each cycle, cnt runs 0..SETS-1. After SETS cycles it moves to RUN.
- State machine RUN: init_done=1, req_ready=1. There is no way back to INIT except through reset.
- A request is accepted when req_valid && req_ready. req_valid while req_ready=0 is ignored; nothing is queued.
- Stage A, cycle T (accept):
  - Register op, set and way.
  - Capture the tree bits from array[req_set].
- Stage B, cycle T+1:
  - Compute the next bits and the victim.
  - Drive rsp_valid=1 and rsp_way.
  - Write array[set] at the end of T+1.
- Latency is 1 cycle from accept to rsp_valid. Throughput is 1 request per cycle. There is no response backpressure.
- Bypass: if stage B is writing set S while stage A captures set S in the same cycle, stage A takes the stage-B next bits, not the array value. Back-to-back same-set requests must behave exactly as if issued with gaps.
- Different sets in consecutive cycles do not interact.
- rst_n asserted mid-operation: in-flight requests are dropped with no response and no write. rsp_valid deasserts immediately. A full init sweep follows.
- rsp_way is held at its last value when rsp_valid=0.

Test Plan:
- Reset release, WAYS=8, SETS=64 -> req_ready=0 for exactly 64 cycles, then req_ready=1 and init_done=1. req_valid pulsed during init -> no rsp_valid.
- VICTIM to set 5 four times back-to-back -> rsp_way 0, 4, 2, 6 on consecutive cycles; the same sequence must appear with idle gaps between requests (checks bypass).
- After init, TOUCH set 9 way 0 then VICTIM set 9 -> rsp_way=4. TOUCH set 9 way 4 then VICTIM set 9 -> rsp_way=2 (path-only update).
- VICTIM set 3 (returns 0), CLEAR set 3, VICTIM set 3 -> rsp_way=0 again, with rsp_way=0 on the CLEAR response. Alternating sets 1 and 2 with VICTIM -> each set independently returns 0, 4, 2, ...
- rst_n dropped in the cycle after a VICTIM accept to set 7 -> no rsp_valid, a 64-cycle sweep follows, then VICTIM set 7 -> rsp_way=0.
- WAYS=2 and WAYS=16 builds: WAYS=2 repeated VICTIM returns 0, 1, 0, 1. WAYS=16 returns 0, 8, 4, 12.

Source files
------------

// File: rtl/plru_set_ctrl.sv
// Tree-PLRU replacement state per cache set: TOUCH, VICTIM (select + touch) and CLEAR requests.
// Latency: 1 cycle from accept to rsp_valid; one request per cycle, same-set bypass between stages.
// Backpressure: req_ready low only during the post-reset init sweep; responses cannot be stalled.
module plru_set_ctrl #(
    parameter int WAYS     = 8,
    parameter int WAYS_REP = $clog2(WAYS),
    parameter int SETS     = 64,
    parameter int SET_BITS = $clog2(SETS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [SET_BITS-1:0] req_set,
    input  logic [WAYS_REP-1:0] req_way,
    output logic                rsp_valid,
    output logic [WAYS_REP-1:0] rsp_way,
    output logic                init_done
);

    // Internal tree nodes per set, heap ordered: node 0 is the root.
    localparam int TB = WAYS - 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    logic [TB-1:0]       r_tree [SETS];

    state_t              r_state;
    logic [SET_BITS-1:0] r_cnt;
    logic                r_ready;
    logic                r_done;

    logic                r_b_vld;
    logic [1:0]          r_b_op;
    logic [SET_BITS-1:0] r_b_set;
    logic [WAYS_REP-1:0] r_b_way;
    logic [TB-1:0]       r_b_bits;
    logic [WAYS_REP-1:0] r_last_way;

    logic                w_acc;
    logic [TB-1:0]       w_cap_bits;
    logic [WAYS_REP-1:0] w_victim;
    logic [TB-1:0]       w_next_bits;
    logic [WAYS_REP-1:0] w_rsp_way;

    // Follow node bits from the root down to a leaf; leaf index minus (WAYS-1) is the way.
    function automatic logic [WAYS_REP-1:0] f_victim(input logic [TB-1:0] bits);
        int   node;
        logic b;
        node = 0;
        for (int l = 0; l < WAYS_REP; l++) begin
            b    = |(bits & (TB'(1) << node));
            node = 2 * node + 1 + int'(b);
        end
        return WAYS_REP'(node - (WAYS - 1));
    endfunction

    // Walk the way's path from the root, making every node on it point away from the way.
    function automatic logic [TB-1:0] f_touch(input logic [TB-1:0] bits,
                                              input logic [WAYS_REP-1:0] way);
        logic [TB-1:0] t;
        int            node;
        logic          dir;
        logic          away;
        t    = bits;
        node = 0;
        for (int l = 0; l < WAYS_REP; l++) begin
            dir  = |(way & (WAYS_REP'(1) << (WAYS_REP - 1 - l)));
            away = ~dir;
            t    = (t & ~(TB'(1) << node)) | (TB'(away) << node);
            node = 2 * node + 1 + int'(dir);
        end
        return t;
    endfunction

    assign w_acc      = req_valid && r_ready;
    // Same-set bypass: the stage-B result is newer than the array copy.
    assign w_cap_bits = (r_b_vld && (r_b_set == req_set)) ? w_next_bits : r_tree[req_set];

    assign req_ready  = r_ready;
    assign init_done  = r_done;
    assign rsp_valid  = r_b_vld;
    assign rsp_way    = r_b_vld ? w_rsp_way : r_last_way;

    // Stage B: next tree bits and response way for the registered request.
    always_comb begin
        w_victim    = f_victim(r_b_bits);
        w_next_bits = '0;
        w_rsp_way   = '0;
        case (r_b_op)
            2'b01: begin
                w_next_bits = f_touch(r_b_bits, w_victim);
                w_rsp_way   = w_victim;
            end
            2'b10: begin
                w_next_bits = '0;
                w_rsp_way   = '0;
            end
            default: begin
                w_next_bits = f_touch(r_b_bits, r_b_way);
                w_rsp_way   = r_b_way;
            end
        endcase
    end

    // Init sweep then permanent RUN; ready/done are registered state outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
        end else if (r_state == ST_INIT) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == SET_BITS'(SETS - 1)) begin
                r_state <= ST_RUN;
                r_ready <= 1'b1;
                r_done  <= 1'b1;
            end
        end
    end

    // Stage A capture into stage B; reset drops any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_vld    <= 1'b0;
            r_b_op     <= '0;
            r_b_set    <= '0;
            r_b_way    <= '0;
            r_b_bits   <= '0;
            r_last_way <= '0;
        end else begin
            r_b_vld <= w_acc;
            if (w_acc) begin
                r_b_op   <= req_op;
                r_b_set  <= req_set;
                r_b_way  <= req_way;
                r_b_bits <= w_cap_bits;
            end
            if (r_b_vld) begin
                r_last_way <= w_rsp_way;
            end
        end
    end

    // Tree array: zeroed by the sweep, otherwise written back at the end of stage B.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_tree[r_cnt] <= '0;
        end else if (r_b_vld) begin
            r_tree[r_b_set] <= w_next_bits;
        end
    end

endmodule
